// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the traffic-light sensor slice:
//   - 2-bit light encoding driven by the controller (GREEN/YELLOW/RED/ILLEGAL)
//   - lane FSM state encoding
//   - departure-timer width and a light decode helper
// Imported by tl_lane, tl_sensor and the controller (tl_cntr).
// ---------------------------------------------------------------------------
package tl_pkg;

  localparam logic [1:0] GREEN   = 2'b00;
  localparam logic [1:0] YELLOW  = 2'b01;
  localparam logic [1:0] RED     = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  // Departure timer holds 1..DEP_CYC, DEP_CYC at most 15.
  localparam int TMR_W = 4;

  typedef enum logic [1:0] {
    LANE_EMPTY = 2'b00,
    LANE_WAIT  = 2'b01,
    LANE_FLOW  = 2'b10
  } lane_state_e;

  // Only the GREEN code lets traffic flow; YELLOW and the illegal code do not.
  function automatic logic is_green(input logic [1:0] light);
    return (light == GREEN);
  endfunction

endpackage

// File: rtl/tl_sensor_if.sv
// ---------------------------------------------------------------------------
// tl_sensor_if
// Bundles the light inputs, arrival pulses and sensor outputs of tl_sensor.
//   master : controller/environment side (drives lights and arrivals)
//   slave  : tl_sensor side (drives sensors, counts and sticky flags)
// ---------------------------------------------------------------------------
interface tl_sensor_if #(
  parameter int QW = 4
);

  logic [1:0]    La;
  logic [1:0]    Lb;
  logic          arr_a;
  logic          arr_b;
  logic          Ta;
  logic          Tb;
  logic [QW-1:0] qcnt_a;
  logic [QW-1:0] qcnt_b;
  logic          ovf_a;
  logic          ovf_b;
  logic          conflict;

  modport master (
    output La, Lb, arr_a, arr_b,
    input  Ta, Tb, qcnt_a, qcnt_b, ovf_a, ovf_b, conflict
  );

  modport slave (
    input  La, Lb, arr_a, arr_b,
    output Ta, Tb, qcnt_a, qcnt_b, ovf_a, ovf_b, conflict
  );

endinterface

// File: rtl/tl_lane.sv
// ---------------------------------------------------------------------------
// tl_lane
// One street: lane FSM (EMPTY/WAIT/FLOW), departure timer, saturating
// vehicle counter and sticky overflow flag.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   i_light     : light code for this street
//   i_arr       : one-cycle arrival pulse
//   o_qcnt      : registered vehicle count
//   o_ovf       : sticky, an arrival was dropped on a full queue
// ---------------------------------------------------------------------------
module tl_lane
  import tl_pkg::*;
#(
  parameter int QW      = 4,
  parameter int DEP_CYC = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    i_light,
  input  logic          i_arr,
  output logic [QW-1:0] o_qcnt,
  output logic          o_ovf
);

  localparam logic [QW-1:0]    Q_MAX   = {QW{1'b1}};
  localparam logic [QW-1:0]    Q_ZERO  = {QW{1'b0}};
  localparam logic [QW-1:0]    Q_ONE   = QW'(1);
  localparam logic [TMR_W-1:0] TMR_END = TMR_W'(DEP_CYC);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_CLR = {TMR_W{1'b0}};

  lane_state_e      r_state;
  logic [QW-1:0]    r_q;
  logic [TMR_W-1:0] r_tmr;
  logic             r_ovf;

  lane_state_e      w_state_nxt;
  logic [QW-1:0]    w_q_nxt;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic             w_ovf_nxt;
  logic             w_green;
  logic             w_dep;

  // Next-state, count, timer and overflow decode for the lane.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_tmr_nxt   = r_tmr;
    w_ovf_nxt   = r_ovf;
    w_green     = is_green(i_light);
    // A departure needs a live green on the edge the timer sits at DEP_CYC;
    // the non-zero guard keeps the count from wrapping below zero.
    w_dep       = (r_state == LANE_FLOW) && w_green &&
                  (r_tmr == TMR_END) && (r_q != Q_ZERO);

    // Coincident arrival and departure cancel, so a full queue does not flag overflow.
    if (i_arr && !w_dep) begin
      if (r_q == Q_MAX) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_q_nxt = r_q + Q_ONE;
      end
    end else if (w_dep && !i_arr) begin
      w_q_nxt = r_q - Q_ONE;
    end else begin
      w_q_nxt = r_q;
    end

    case (r_state)
      LANE_EMPTY: begin
        if (i_arr) begin
          w_state_nxt = w_green ? LANE_FLOW : LANE_WAIT;
        end else begin
          w_state_nxt = LANE_EMPTY;
        end
      end
      LANE_WAIT: begin
        if (w_green) begin
          w_state_nxt = LANE_FLOW;
        end else begin
          w_state_nxt = LANE_WAIT;
        end
      end
      LANE_FLOW: begin
        if (!w_green) begin
          w_state_nxt = LANE_WAIT;
        end else if (w_q_nxt == Q_ZERO) begin
          w_state_nxt = LANE_EMPTY;
        end else begin
          w_state_nxt = LANE_FLOW;
        end
      end
      default: begin
        w_state_nxt = LANE_EMPTY;
      end
    endcase

    // Timer starts at 1 on the edge that enters FLOW, so the first departure
    // lands DEP_CYC edges after green is first sampled with vehicles queued.
    if (w_state_nxt == LANE_FLOW) begin
      if (r_state != LANE_FLOW) begin
        w_tmr_nxt = TMR_ONE;
      end else if (w_dep) begin
        w_tmr_nxt = TMR_ONE;
      end else begin
        w_tmr_nxt = r_tmr + TMR_ONE;
      end
    end else begin
      w_tmr_nxt = TMR_CLR;
    end
  end

  // Lane state, count, timer and overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LANE_EMPTY;
      r_q     <= Q_ZERO;
      r_tmr   <= TMR_CLR;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_tmr   <= w_tmr_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign o_qcnt = r_q;
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/tl_sensor.sv
// ---------------------------------------------------------------------------
// tl_sensor
// Vehicle-queue sensor for a two-street intersection. Two tl_lane instances
// track the queues; the top decodes Ta/Tb and watches for unsafe lights.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : tl_sensor_if.slave (La, Lb, arr_a, arr_b in;
//                Ta, Tb, qcnt_a, qcnt_b, ovf_a, ovf_b, conflict out)
// ---------------------------------------------------------------------------
module tl_sensor
  import tl_pkg::*;
#(
  parameter int QW      = 4,
  parameter int DEP_CYC = 3
) (
  input  logic          clk,
  input  logic          reset,
  tl_sensor_if.slave    bus
);

  logic [QW-1:0] w_qcnt_a;
  logic [QW-1:0] w_qcnt_b;
  logic          w_ovf_a;
  logic          w_ovf_b;
  logic          w_unsafe;
  logic          r_conflict;

  tl_lane #(.QW(QW), .DEP_CYC(DEP_CYC)) u_lane_a (
    .clk     (clk),
    .reset   (reset),
    .i_light (bus.La),
    .i_arr   (bus.arr_a),
    .o_qcnt  (w_qcnt_a),
    .o_ovf   (w_ovf_a)
  );

  tl_lane #(.QW(QW), .DEP_CYC(DEP_CYC)) u_lane_b (
    .clk     (clk),
    .reset   (reset),
    .i_light (bus.Lb),
    .i_arr   (bus.arr_b),
    .o_qcnt  (w_qcnt_b),
    .o_ovf   (w_ovf_b)
  );

  // Unsafe when neither street is held at RED, or any light code is illegal.
  always_comb begin
    w_unsafe = ((bus.La != RED) && (bus.Lb != RED)) ||
               (bus.La == ILLEGAL) || (bus.Lb == ILLEGAL);
  end

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= r_conflict | w_unsafe;
    end
  end

  assign bus.qcnt_a   = w_qcnt_a;
  assign bus.qcnt_b   = w_qcnt_b;
  assign bus.Ta       = |w_qcnt_a;
  assign bus.Tb       = |w_qcnt_b;
  assign bus.ovf_a    = w_ovf_a;
  assign bus.ovf_b    = w_ovf_b;
  assign bus.conflict = r_conflict;

endmodule

// File: doc/tl_sensor.md
TL_SENSOR -- requirements
Module: tl_sensor

Interface
REQ-001 Parameter QW, default 4: queue-count width; maximum queue depth is 2^QW-1 (15).
REQ-002 Parameter DEP_CYC, default 3: clock cycles of green per vehicle departure; legal range 1..15.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 La  input  2  street-A light from controller: 2'b00 GREEN, 2'b01 YELLOW, 2'b10 RED, 2'b11 illegal.
REQ-006 Lb  input  2  street-B light, same encoding as La.
REQ-007 arr_a  input  1  one-cycle vehicle-arrival pulse, street A; high for k cycles = k arrivals.
REQ-008 arr_b  input  1  vehicle-arrival pulse, street B.
REQ-009 Ta  output  1  street-A traffic sensor to controller: 1 when qcnt_a != 0.
REQ-010 Tb  output  1  street-B traffic sensor: 1 when qcnt_b != 0.
REQ-011 qcnt_a  output  QW  vehicles queued on street A.
REQ-012 qcnt_b  output  QW  vehicles queued on street B.
REQ-013 ovf_a, ovf_b  output  1 each  sticky: arrival dropped because the queue was full.
REQ-014 conflict  output  1  sticky: unsafe or illegal light combination sampled.

Function
REQ-015 Each street SHALL run an independent lane FSM: EMPTY (q=0), WAIT (q>0, light not GREEN), FLOW (q>0, light GREEN).
REQ-016 Transitions SHALL be: EMPTY->WAIT on arrival when light not GREEN; EMPTY->FLOW on arrival when light GREEN; WAIT->FLOW when light becomes GREEN; FLOW->WAIT when light leaves GREEN; FLOW->EMPTY when the last vehicle departs with no arrival that cycle.
REQ-017 In FLOW, a departure timer SHALL count 1..DEP_CYC; on the cycle it reaches DEP_CYC, q decrements by 1 and the timer reloads to 1.
REQ-018 The timer SHALL clear to 0 in any state other than FLOW; YELLOW counts as not GREEN (no departures).
REQ-019 First departure after entering FLOW SHALL occur DEP_CYC rising edges after the first edge that samples GREEN with q>0.
REQ-020 Arrival and departure in the same cycle SHALL leave q unchanged; the timer still reloads.
REQ-021 Arrival at q=2^QW-1 SHALL saturate q and set ovf; if a departure coincides, the net is q unchanged and ovf SHALL NOT set.
REQ-022 Departure SHALL never take q below 0.
REQ-023 Ta/Tb SHALL be combinational decodes of the registered counts (no extra latency beyond the count register).
REQ-024 conflict SHALL set on any edge sampling La!=RED and Lb!=RED together, or either light equal to 2'b11; it stays set until reset.
REQ-025 An illegal light code SHALL be treated as not GREEN by the lane FSM.

Reset
REQ-026 While reset is high: all lane FSMs in EMPTY, q=0, timers=0, Ta=Tb=0, ovf_a=ovf_b=0, conflict=0.
REQ-027 Reset asserted mid-FLOW SHALL discard queued vehicles immediately (asynchronous); the first edge after deassertion evaluates from EMPTY.

Structure
REQ-028 Package tl_pkg SHALL hold the light-encoding constants (GREEN, YELLOW, RED, ILLEGAL) and the lane-state encoding, shared with tl_cntr.
REQ-029 One sub-module tl_lane (FSM, timer, counter, ovf) SHALL be instantiated twice; the conflict check lives in tl_sensor top.

Verification
REQ-030 Reset, 3 arr_a pulses with La=RED -> qcnt_a=3, Ta=1, no decrement.
REQ-031 q_a=3, La->GREEN (DEP_CYC=3) -> qcnt_a 2,1,0 at edges 3,6,9 after GREEN sampled; Ta falls with q=0.
REQ-032 q_b=2, Lb GREEN, arr_b on a departure edge -> qcnt_b stays 2; Lb->YELLOW mid-timer -> count frozen, timer cleared.
REQ-033 16 arr_a pulses, La=RED -> qcnt_a=15, ovf_a=1 from 16th edge; ovf_a held until reset.
REQ-034 La=GREEN and Lb=YELLOW in the same cycle, then La=2'b11 -> conflict=1 after first edge, stays 1.
REQ-035 Reset pulse asserted between edges with q_a=5 in FLOW -> qcnt_a=0, Ta=0 immediately, no wait for clk.
